// File: rtl/mfp_uart_transmitter_pkg.sv
// Shared constants, FSM state encoding and helpers for the mfp UART transmitter.
// Optional even-parity support is enabled by defining MFP_UART_TX_PARITY_EN.
package mfp_uart_transmitter_pkg;

  localparam int DEFAULT_CLOCK_FREQUENCY = 50000000;
  localparam int DEFAULT_BAUD_RATE       = 115200;
  localparam int DEFAULT_FIFO_DEPTH      = 16;
  localparam int DATA_BITS               = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef MFP_UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic logic is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

`ifdef MFP_UART_TX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction
`endif

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; pointers wrap modulo DEPTH.
module mfp_uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_d;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             push_s;
  logic             pop_s;

  // Requests against a full or empty FIFO are dropped rather than corrupting state.
  assign push_s = push_i && (count_q != DEPTH[AW:0]);
  assign pop_s  = pop_i && (count_q != {(AW+1){1'b0}});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == DEPTH[AW:0]);
  assign empty_o = (count_q == {(AW+1){1'b0}});
  assign count_o = count_q;

endmodule

// File: rtl/mfp_uart_transmitter.sv
// Serial UART transmitter (8N1, or 8E1 when MFP_UART_TX_PARITY_EN is defined) with an input FIFO.
// Frames are sent LSB-first, back-to-back with no idle gap while the FIFO has data.
module mfp_uart_transmitter
  import mfp_uart_transmitter_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
  parameter int BAUD_RATE       = DEFAULT_BAUD_RATE,
  parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [7:0]                    byte_data,
  input  logic                          byte_valid,
  output logic                          byte_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("mfp_uart_transmitter: CLOCK_FREQUENCY/BAUD_RATE must be at least 2");
  end
  if (!is_pow2(FIFO_DEPTH)) begin : g_depth_check
    $error("mfp_uart_transmitter: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_e                   state_q;
  tx_state_e                   state_d;
  logic [CW-1:0]               cnt_q;
  logic [CW-1:0]               cnt_d;
  logic [2:0]                  bit_idx_q;
  logic [2:0]                  bit_idx_d;
  logic [7:0]                  shift_q;
  logic [7:0]                  shift_d;
  logic                        tx_q;
  logic                        tx_d;
  logic                        pop_s;
  logic                        push_s;
  logic                        bit_end_s;
  logic                        fifo_full_s;
  logic                        fifo_empty_s;
  logic [7:0]                  fifo_rdata_s;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_s;

  assign push_s    = byte_valid && !fifo_full_s;
  assign bit_end_s = (cnt_q == CNT_LAST);

  mfp_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (byte_data),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // tx_d is the line level for the bit that begins on the next edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_rdata_s;
          tx_d    = 1'b0;
          state_d = ST_START;
        end else begin
          tx_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          cnt_d     = CNT_ZERO;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_d = CNT_ZERO;
          if (bit_idx_q == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
            tx_d    = even_parity(shift_q);
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef MFP_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) begin
          cnt_d   = CNT_ZERO;
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end_s) begin
          cnt_d = CNT_ZERO;
          // Chain straight into the next start bit so queued bytes leave without an idle gap.
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = fifo_rdata_s;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign byte_ready = !fifo_full_s;
  assign fifo_count = fifo_count_s;
  assign busy       = (state_q != ST_IDLE) || (fifo_count_s != {($clog2(FIFO_DEPTH)+1){1'b0}});

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Self-checking bench for mfp_uart_transmitter: the line is decoded against frames built from the byte stream.
module tb_mfp_uart_transmitter;

  localparam int DIV   = 10;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef MFP_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic          clock      = 1'b0;
  logic          reset_n    = 1'b0;
  logic [7:0]    byte_data  = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mfp_uart_transmitter #(
    .CLOCK_FREQUENCY (50),
    .BAUD_RATE       (5),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // Bit k of the serial frame for byte b: start, 8 data LSB first, [even parity], stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NBITS == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Entered on the first sample of the start bit; each bit must hold for exactly DIV samples.
  task automatic expect_frame(input logic [7:0] b, input string name,
                              input bit do_push, input logic [7:0] pdata);
    for (int k = 0; k < NBITS; k++) begin
      int   bad;
      logic exp_v;
      bad   = 0;
      exp_v = frame_bit(b, k);
      for (int c = 0; c < DIV; c++) begin
        if (tx !== exp_v) bad++;
        if (do_push && k == NBITS-1 && c == DIV-1) begin
          byte_data  = pdata;
          byte_valid = 1'b1;
        end
        @(negedge clock);
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL %s byte %h bit %0d: %0d of %0d samples wrong, required tx=%b",
                 name, b, k, bad, DIV, exp_v);
      end
    end
    if (do_push) byte_valid = 1'b0;
  endtask

  task automatic wait_start(input string name, input int budget);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    n_checks++;
    if (tx !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: no start bit within %0d clocks, tx=%b required 0", name, budget, tx);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || fifo_count !== CW'(0)) begin
      n_fail++;
      $display("FAIL %s: busy=%b tx=%b count=%0d, required busy=0 tx=1 count=0",
               name, busy, tx, fifo_count);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b1 || fifo_count !== CW'(0)) begin
      n_fail++;
      $display("FAIL reset_state: tx=%b busy=%b ready=%b count=%0d, required 1 0 1 0",
               tx, busy, byte_ready, fifo_count);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check_idle("after_reset_release");
  endtask

  task automatic test_single_a5();
    byte_data  = 8'hA5;
    byte_valid = 1'b1;
    @(negedge clock);
    byte_valid = 1'b0;
    n_checks++;
    if (tx !== 1'b1 || fifo_count !== CW'(1) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL a5_accept: tx=%b count=%0d busy=%b, required 1 1 1", tx, fifo_count, busy);
    end
    @(negedge clock);
    n_checks++;
    if (tx !== 1'b0 || fifo_count !== CW'(0)) begin
      n_fail++;
      $display("FAIL a5_latency: tx=%b count=%0d, required tx=0 count=0", tx, fifo_count);
    end
    expect_frame(8'hA5, "a5", 1'b0, 8'h00);
    check_idle("a5_end");
  endtask

  task automatic test_random_single();
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      push_byte(b);
      wait_start("rand_single", 3);
      expect_frame(b, "rand_single", 1'b0, 8'h00);
      check_idle("rand_single_end");
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bytes [3];
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          byte_data  = bytes[i];
          byte_valid = 1'b1;
          @(negedge clock);
        end
        byte_valid = 1'b0;
      end
      begin
        wait_start("b2b", 5);
        for (int i = 0; i < 3; i++) begin
          if (i > 0) begin
            n_checks++;
            if (fifo_count !== CW'(3 - (i + 1))) begin
              n_fail++;
              $display("FAIL b2b_count frame %0d: count=%0d required %0d", i, fifo_count, 3 - (i + 1));
            end
          end
          expect_frame(bytes[i], "b2b", 1'b0, 8'h00);
        end
      end
    join
    check_idle("b2b_end");
  endtask

  task automatic test_full();
    logic [7:0] d [17];
    for (int i = 0; i < 17; i++) d[i] = 8'($urandom);
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          byte_data  = d[i];
          byte_valid = 1'b1;
          n_checks++;
          if (byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_ready push %0d: ready=%b required 1", i, byte_ready);
          end
          @(negedge clock);
        end
        byte_data = 8'hEE;
        repeat (5) begin
          n_checks++;
          if (byte_ready !== 1'b0 || fifo_count !== CW'(16)) begin
            n_fail++;
            $display("FAIL full_hold: ready=%b count=%0d, required ready=0 count=16", byte_ready, fifo_count);
          end
          @(negedge clock);
        end
        byte_valid = 1'b0;
      end
      begin
        wait_start("full", 5);
        for (int i = 0; i < 17; i++) expect_frame(d[i], "full", 1'b0, 8'h00);
      end
    join
    check_idle("full_end");
  endtask

  task automatic test_push_pop();
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    a = 8'($urandom);
    b = 8'($urandom);
    c = 8'($urandom);
    push_byte(a);
    push_byte(b);
    expect_frame(a, "pushpop_a", 1'b1, c);
    n_checks++;
    if (fifo_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL pushpop_count: count=%0d required 1", fifo_count);
    end
    expect_frame(b, "pushpop_b", 1'b0, 8'h00);
    expect_frame(c, "pushpop_c", 1'b0, 8'h00);
    check_idle("pushpop_end");
  endtask

  task automatic test_reset_mid();
    int bad;
    logic [7:0] b;
    for (int i = 0; i < 5; i++) begin
      byte_data  = (i == 0) ? 8'h3C : 8'($urandom);
      byte_valid = 1'b1;
      @(negedge clock);
    end
    byte_valid = 1'b0;
    repeat (30) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (tx !== 1'b1 || fifo_count !== CW'(0) || busy !== 1'b0 || byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: tx=%b count=%0d busy=%b ready=%b, required 1 0 0 1",
               tx, fifo_count, busy, byte_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: %0d of 60 samples active, required 0", bad);
    end
    b = 8'($urandom);
    push_byte(b);
    wait_start("reset_mid_new", 3);
    expect_frame(b, "reset_mid_new", 1'b0, 8'h00);
    check_idle("reset_mid_end");
  endtask

`ifdef MFP_UART_TX_PARITY_EN
  task automatic test_parity();
    push_byte(8'h07);
    wait_start("parity_07", 3);
    expect_frame(8'h07, "parity_07", 1'b0, 8'h00);
    check_idle("parity_07_end");
    push_byte(8'h03);
    wait_start("parity_03", 3);
    expect_frame(8'h03, "parity_03", 1'b0, 8'h00);
    check_idle("parity_03_end");
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clock);
    test_reset();
    test_single_a5();
    test_random_single();
    test_back_to_back(8'h00, 8'hFF, 8'h55);
    test_back_to_back(8'($urandom), 8'($urandom), 8'($urandom));
    test_full();
    test_push_pop();
    test_reset_mid();
`ifdef MFP_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
